cont_config_axil_slave: RTL and testbench

AXI4-Lite slave register file that responds to the configuration master. It holds NUM_REGS 32-bit read/write control registers and presents them to the fabric. Write address and write data channels are accepted independently; B and R channels tolerate arbitrary backpressure. Out-of-range accesses return SLVERR.

---
 rtl/cont_config_axil_slave.sv | 172 +++++++++++++++++
 tb/tb_cont_config_axil_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cont_config_axil_slave.sv
// AXI4-Lite register file for the configuration master.
// Independent AW/W capture, backpressure-tolerant B/R, SLVERR when out of range.
module cont_config_axil_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [31:0] NREG = NUM_REGS;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                  aw_held_q, aw_held_d;
    logic [IW-1:0]         aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [SW-1:0]         w_strb_q, w_strb_d;
    logic                  b_valid_q, b_valid_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = !ARESET && !aw_held_q;
    assign S_AXI_WREADY  = !ARESET && !w_held_q;
    assign S_AXI_ARREADY = !ARESET && (!r_valid_q || S_AXI_RREADY);
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign reg_wr_pulse  = pulse_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_held_q && w_held_q && (!b_valid_q || S_AXI_BREADY);
    assign wr_ok  = 32'(aw_idx_q) < NREG;
    assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign rd_ok  = 32'(rd_idx) < NREG;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_view
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IW'(k)) rd_val = regs_q[k];
        end
    end

    // Write path: a held channel is only re-opened by its own commit.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? OKAY : SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_ok && aw_idx_q == IW'(k)) begin
                    pulse_d[k] = 1'b1;
                    for (int b = 0; b < SW; b++) begin
                        if (w_strb_q[b]) regs_d[k][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end else if (b_valid_q && S_AXI_BREADY) begin
            b_valid_d = 1'b0;
        end
    end

    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_ok ? rd_val : '0;
            r_resp_d  = rd_ok ? OKAY : SLVERR;
        end else if (r_valid_q && S_AXI_RREADY) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= OKAY;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
            pulse_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            pulse_q   <= pulse_d;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
        end
    end
endmodule

// File: tb/tb_cont_config_axil_slave.sv
// Scoreboard bench for cont_config_axil_slave (ADDR_WIDTH=5, 4 registers).
module tb_cont_config_axil_slave;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [127:0]  reg_out;
    logic [3:0]    pulse;

    always #5 clk = ~clk;

    cont_config_axil_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(4)) dut (
        .ACLK(clk), .ARESET(arst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .reg_wr_pulse(pulse)
    );

    int checks = 0;
    int failures = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] mdl[4];
    int          pcnt[4];
    int          pdbl = 0;
    logic [3:0]  pprev = '0;
    logic [31:0] old1;
    int          psum;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mdl_cat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    // Handshakes are sampled mid-cycle; they complete on the next rising edge.
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", 128'(bresp), 128'(bq.pop_front()));
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", 1, 0);
            else check("rresp_rdata", 128'({rresp, rdata}), 128'(rq.pop_front()));
        end
        for (int k = 0; k < 4; k++) if (pulse[k]) pcnt[k]++;
        if ((pulse & pprev) != 0) pdbl++;
        pprev = pulse;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        int idx;
        logic ah, wh;
        idx = int'(a[4:2]);
        if (idx < 4) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
            @(negedge clk);
            ah = awvalid && awready;
            wh = wvalid && wready;
            tick();
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            check("wr_timeout", 1, 0);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int idx;
        logic hs;
        hs = 1'b0;
        idx = int'(a[4:2]);
        if (idx < 4) rq.push_back({2'b00, mdl[idx]});
        else rq.push_back({2'b10, 32'h0});
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = arready;
            tick();
        end
        arvalid = 1'b0;
        if (!hs) check("rd_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && (bq.size() != 0 || rq.size() != 0); n++) tick();
        if (bq.size() != 0 || rq.size() != 0) check("drain_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 4; k++) begin mdl[k] = '0; pcnt[k] = 0; end
        tick(); tick();
        check("rst_awready", 128'(awready), 0);
        check("rst_wready", 128'(wready), 0);
        check("rst_arready", 128'(arready), 0);
        arst = 1'b0;
        tick();
        check("rst_reg_out", reg_out, 0);
        check("rst_b", 128'({bvalid, bresp}), 0);
        check("rst_r", 128'({rvalid, rresp, rdata}), 0);
        check("rst_pulse", 128'(pulse), 0);

        // 1: basic writes and reads
        for (int i = 0; i < 4; i++) wr(AW'(4 * i), 32'(i + 1), 4'hF);
        drain();
        check("t1_reg_out", reg_out,
              128'h00000004_00000003_00000002_00000001);
        for (int k = 0; k < 4; k++) check("t1_pulse_cnt", 128'(pcnt[k]), 1);
        for (int i = 0; i < 4; i++) rd(AW'(4 * i));
        drain();

        // 2: byte strobes
        wr(5'h04, 32'hAABBCCDD, 4'hF);
        wr(5'h04, 32'h11223344, 4'b0101);
        drain();
        check("t2_reg1", 128'(reg_out[63:32]), 128'(32'hAA22CC44));
        rd(5'h04);
        drain();

        // 3: out of range
        psum = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
        wr(5'h10, 32'hDEADBEEF, 4'hF);
        rd(5'h10);
        drain();
        check("t3_no_pulse", 128'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 128'(psum));
        check("t3_regs", reg_out, mdl_cat());

        // 4: W early, B backpressure, second write held off
        bready = 1'b0;
        mdl[0] = 32'h0000AAAA;
        bq.push_back(2'b00);
        awaddr = 5'h00; wdata = 32'h0000AAAA; wstrb = 4'hF;
        wvalid = 1'b1;
        check("t4_wready", 128'(wready), 1);
        tick();
        wvalid = 1'b0;
        check("t4_w_held", 128'(wready), 0);
        tick(); tick();
        awvalid = 1'b1;
        check("t4_awready", 128'(awready), 1);
        tick();
        awvalid = 1'b0;
        check("t4_b_early", 128'(bvalid), 0);
        tick();
        check("t4_bvalid", 128'(bvalid), 1);
        old1 = mdl[1];
        mdl[1] = 32'h12345678;
        bq.push_back(2'b00);
        awaddr = 5'h04; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        check("t4_2nd_ready", 128'({awready, wready}), 128'(2'b11));
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t4_2nd_held", 128'({awready, wready}), 0);
        for (int i = 0; i < 3; i++) begin
            check("t4_b_hold", 128'(bvalid), 1);
            check("t4_reg1_old", 128'(reg_out[63:32]), 128'(old1));
            tick();
        end
        check("t4_b_hold", 128'(bvalid), 1);
        bready = 1'b1;
        tick();
        check("t4_b_2nd", 128'(bvalid), 1);
        check("t4_reg1_new", 128'(reg_out[63:32]), 128'(32'h12345678));
        tick();
        check("t4_b_done", 128'(bvalid), 0);
        drain();

        // 5: read and write of the same register on the same edge
        rq.push_back({2'b00, mdl[2]});
        mdl[2] = 32'h55;
        bq.push_back(2'b00);
        awaddr = 5'h08; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h08; arvalid = 1'b1;
        check("t5_arready", 128'(arready), 1);
        tick();
        arvalid = 1'b0;
        drain();
        rd(5'h08);
        drain();

        // 6: reset with pending B and held AW
        bready = 1'b0;
        awaddr = 5'h00; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("t6_b_pending", 128'(bvalid), 1);
        awaddr = 5'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t6_aw_held", 128'(awready), 0);
        arst = 1'b1;
        tick();
        check("t6_rst_ready", 128'({awready, wready, arready}), 0);
        arst = 1'b0;
        bready = 1'b1;
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        check("t6_bvalid", 128'(bvalid), 0);
        check("t6_regs", reg_out, 0);
        wdata = 32'h99; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_no_commit", 128'({bvalid, pulse}), 0);
            tick();
        end
        mdl[3] = 32'h99;
        bq.push_back(2'b00);
        awaddr = 5'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        drain();
        check("t6_regs_after", reg_out, mdl_cat());

        tick(); tick();
        check("pulse_width", 128'(pdbl), 0);
        check("sb_empty", 128'(bq.size() + rq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
